// File: rtl/trng_collector.sv
// Consumer side of the ring-oscillator TRNG: synchronizes the raw bit, optionally applies
// von Neumann debiasing, runs a repetition-count health test and offers words over valid/ready.
module trng_collector #(
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 256,
    parameter int REP_LIMIT     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  debias_en,
    output logic                  trng_en,
    input  logic                  trng_in,
    output logic [WORD_WIDTH-1:0] rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic                  health_fail
);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
    localparam logic [WW-1:0] WARM_ZERO = WW'(0);
    localparam logic [WW-1:0] WARM_ONE  = WW'(1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [RW-1:0] RUN_ZERO  = RW'(0);
    localparam logic [RW-1:0] RUN_ONE   = RW'(1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(REP_LIMIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        COLLECT = 3'd2,
        FULL    = 3'd3,
        FAIL    = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [1:0]            sync_r;
    logic                  sbit_s;
    logic [WW-1:0]         warm_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [RW-1:0]         run_cnt_r;
    logic [RW-1:0]         run_next_s;
    logic                  last_bit_r;
    logic                  pair_have_r;
    logic                  pair_first_r;
    logic                  debias_r;
    logic [WORD_WIDTH-1:0] rnd_data_r;
    logic                  rnd_valid_r;
    logic                  trng_en_r;
    logic                  health_fail_r;
    logic                  accept_s;
    logic                  accept_bit_s;
    logic                  word_done_s;
    logic                  handshake_s;
    logic                  run_hit_s;

    assign sbit_s      = sync_r[1];
    assign trng_en     = trng_en_r;
    assign rnd_data    = rnd_data_r;
    assign rnd_valid   = rnd_valid_r;
    assign health_fail = health_fail_r;

    // Two-flop synchronizer for the free-running oscillator bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], trng_in};
        end
    end

    // Run-length update, bit acceptance (first bit of an unequal pair) and handshake decode
    always_comb begin
        run_next_s   = RUN_ONE;
        accept_s     = 1'b0;
        accept_bit_s = sbit_s;
        if ((run_cnt_r == RUN_ZERO) || (sbit_s != last_bit_r)) begin
            run_next_s = RUN_ONE;
        end else if (run_cnt_r == RUN_MAX) begin
            run_next_s = RUN_MAX;
        end else begin
            run_next_s = run_cnt_r + RUN_ONE;
        end
        run_hit_s = ((state_r == COLLECT) || (state_r == FULL)) && (run_next_s == RUN_MAX);
        if (state_r != COLLECT) begin
            accept_s = 1'b0;
        end else if (!debias_r) begin
            accept_s = 1'b1;
        end else if (pair_have_r && (pair_first_r != sbit_s)) begin
            accept_s     = 1'b1;
            accept_bit_s = pair_first_r;
        end else begin
            accept_s = 1'b0;
        end
        word_done_s = accept_s && (bit_cnt_r == BIT_LAST);
        handshake_s = (state_r == FULL) && rnd_valid_r && rnd_ready;
    end

    // Next-state selection; a health hit outranks word completion and handshake
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = WARMUP;
                WARMUP:  state_next_s = (warm_cnt_r == WARM_LAST) ? COLLECT : WARMUP;
                COLLECT: begin
                    if (run_hit_s) begin
                        state_next_s = FAIL;
                    end else if (word_done_s) begin
                        state_next_s = FULL;
                    end else begin
                        state_next_s = COLLECT;
                    end
                end
                FULL: begin
                    if (run_hit_s) begin
                        state_next_s = FAIL;
                    end else if (handshake_s) begin
                        state_next_s = COLLECT;
                    end else begin
                        state_next_s = FULL;
                    end
                end
                FAIL:    state_next_s = FAIL;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register and registered outputs; valid rises one cycle after FULL is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            trng_en_r     <= 1'b0;
            rnd_valid_r   <= 1'b0;
            health_fail_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            trng_en_r     <= (state_next_s == WARMUP) || (state_next_s == COLLECT) ||
                             (state_next_s == FULL);
            rnd_valid_r   <= (state_r == FULL) && (state_next_s == FULL);
            health_fail_r <= (state_next_s == FAIL);
        end
    end

    // Counters, pair latch and word shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt_r   <= WARM_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            run_cnt_r    <= RUN_ZERO;
            last_bit_r   <= 1'b0;
            pair_have_r  <= 1'b0;
            pair_first_r <= 1'b0;
            debias_r     <= 1'b0;
            rnd_data_r   <= {WORD_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    debias_r   <= debias_en;
                    warm_cnt_r <= WARM_ZERO;
                end
                WARMUP: begin
                    warm_cnt_r  <= warm_cnt_r + WARM_ONE;
                    bit_cnt_r   <= BIT_ZERO;
                    run_cnt_r   <= RUN_ZERO;
                    pair_have_r <= 1'b0;
                end
                COLLECT: begin
                    run_cnt_r  <= run_next_s;
                    last_bit_r <= sbit_s;
                    if (debias_r) begin
                        pair_have_r <= ~pair_have_r;
                        if (!pair_have_r) begin
                            pair_first_r <= sbit_s;
                        end
                    end
                    if (accept_s) begin
                        rnd_data_r <= {rnd_data_r[WORD_WIDTH-2:0], accept_bit_s};
                        bit_cnt_r  <= bit_cnt_r + BIT_ONE;
                    end
                end
                FULL: begin
                    run_cnt_r  <= run_next_s;
                    last_bit_r <= sbit_s;
                    if (handshake_s) begin
                        bit_cnt_r   <= BIT_ZERO;
                        pair_have_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: a queue-based behavioural model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_trng_collector;
    localparam int WW  = 8;
    localparam int WU  = 4;
    localparam int REP = 6;

    localparam int M_OFF = 0, M_WARM = 1, M_GATHER = 2, M_OFFER = 3, M_HALT = 4;

    logic          clk, reset, enable, debias_en, trng_en, trng_in;
    logic          rnd_valid, rnd_ready, health_fail;
    logic [WW-1:0] rnd_data;

    int vectors     = 0;
    int miscompares = 0;

    trng_collector #(.WORD_WIDTH(WW), .WARMUP_CYCLES(WU), .REP_LIMIT(REP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .debias_en(debias_en),
        .trng_en(trng_en), .trng_in(trng_in), .rnd_data(rnd_data),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the spec says the block is doing, tracked with queues and counts
    int            m_mode = M_OFF;
    int            warm_left, run_len, offer_age;
    bit            s1, s2, sb, last_b, m_deb, took, started;
    bit            acc_q[$];
    bit            pend_q[$];
    logic [WW-1:0] exp_data;
    bit            exp_en, exp_valid, exp_fail;

    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1; m_mode = M_OFF; s1 = 1'b0; s2 = 1'b0; m_deb = 1'b0; run_len = 0;
            acc_q.delete(); pend_q.delete();
            exp_data = '0; exp_en = 1'b0; exp_valid = 1'b0; exp_fail = 1'b0;
        end else begin
            sb = s2; s2 = s1; s1 = trng_in;
            took = exp_valid && rnd_ready;
            if (m_mode == M_OFF) m_deb = debias_en;
            if (!enable) begin
                m_mode = M_OFF;
            end else begin
                case (m_mode)
                    M_OFF: begin m_mode = M_WARM; warm_left = WU; end
                    M_WARM: begin
                        warm_left--;
                        if (warm_left == 0) begin
                            m_mode = M_GATHER; run_len = 0; acc_q.delete(); pend_q.delete();
                        end
                    end
                    M_GATHER, M_OFFER: begin
                        if (run_len == 0 || sb != last_b) run_len = 1;
                        else if (run_len < REP) run_len++;
                        last_b = sb;
                        if (run_len >= REP) begin
                            m_mode = M_HALT;
                        end else if (m_mode == M_GATHER) begin
                            if (!m_deb) begin
                                acc_q.push_back(sb);
                            end else begin
                                pend_q.push_back(sb);
                                if (pend_q.size() == 2) begin
                                    if (pend_q[0] != pend_q[1]) acc_q.push_back(pend_q[0]);
                                    pend_q.delete();
                                end
                            end
                            if (acc_q.size() == WW) begin
                                for (int i = 0; i < WW; i++) exp_data[WW-1-i] = acc_q[i];
                                acc_q.delete();
                                m_mode = M_OFFER; offer_age = 0;
                            end
                        end else if (took) begin
                            m_mode = M_GATHER; acc_q.delete(); pend_q.delete();
                        end else begin
                            offer_age++;
                        end
                    end
                    default: ;
                endcase
            end
            exp_en    = (m_mode == M_WARM) || (m_mode == M_GATHER) || (m_mode == M_OFFER);
            exp_fail  = (m_mode == M_HALT);
            exp_valid = (m_mode == M_OFFER) && (offer_age >= 1);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_trng_en", 32'(trng_en), 32'(exp_en));
            check("cyc_rnd_valid", 32'(rnd_valid), 32'(exp_valid));
            check("cyc_health_fail", 32'(health_fail), 32'(exp_fail));
            if (exp_valid) check("cyc_rnd_data", 32'(rnd_data), 32'(exp_data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic alt(input int n);
        for (int i = 0; i < n; i++) begin
            trng_in = ~trng_in;
            cyc();
        end
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            trng_in = bits[i];
            cyc();
        end
    endtask

    logic          v;
    logic [WW-1:0] w_exp;

    initial begin
        reset = 1'b1; enable = 1'b0; debias_en = 1'b0; rnd_ready = 1'b0; trng_in = 1'b0;
        cyc(); cyc();
        check("rst_trng_en", 32'(trng_en), 32'd0);
        check("rst_rnd_valid", 32'(rnd_valid), 32'd0);
        check("rst_rnd_data", 32'(rnd_data), 32'd0);
        check("rst_health_fail", 32'(health_fail), 32'd0);
        reset = 1'b0; cyc();

        // T1: debias off, raw word 1,0,1,1,0,1,0,0 lands at edges 3..10
        enable = 1'b1; trng_in = 1'b0; cyc();
        check("t1_trng_en_cycle1", 32'(trng_en), 32'd1);
        alt(2);
        feed(32'hB4, 8);
        alt(2);
        check("t1_valid_before_latency", 32'(rnd_valid), 32'd0);
        alt(1);
        check("t1_valid_at_latency", 32'(rnd_valid), 32'd1);
        check("t1_data", 32'(rnd_data), 32'h0000_00B4);

        // T3: hold off the consumer, then accept; next word counts from empty
        for (int i = 0; i < 20; i++) begin
            alt(1);
            check("t3_valid_held", 32'(rnd_valid), 32'd1);
            check("t3_data_held", 32'(rnd_data), 32'h0000_00B4);
        end
        rnd_ready = 1'b1; alt(1); rnd_ready = 1'b0;
        v = trng_in;
        w_exp = v ? 8'h55 : 8'hAA;
        check("t3_valid_drop", 32'(rnd_valid), 32'd0);
        alt(8);
        check("t3_next_not_early", 32'(rnd_valid), 32'd0);
        alt(1);
        check("t3_next_valid", 32'(rnd_valid), 32'd1);
        check("t3_next_data", 32'(rnd_data), 32'(w_exp));

        // T2: debias latched in IDLE, later changes to debias_en ignored
        enable = 1'b0; debias_en = 1'b1; cyc();
        check("t2_idle_trng_en", 32'(trng_en), 32'd0);
        check("t2_idle_valid", 32'(rnd_valid), 32'd0);
        cyc();
        enable = 1'b1; cyc();
        debias_en = 1'b0;
        alt(2);
        feed(32'h0007_8A59, 20);
        alt(2);
        check("t2_valid_early", 32'(rnd_valid), 32'd0);
        alt(1);
        check("t2_valid", 32'(rnd_valid), 32'd1);
        check("t2_data", 32'(rnd_data), 32'h0000_0072);
        rnd_ready = 1'b1; alt(1); rnd_ready = 1'b0;

        // T4: stuck-at-1 trips the repetition test; only enable=0 leaves FAIL
        feed(32'hFF, 8);
        check("t4_health_fail", 32'(health_fail), 32'd1);
        check("t4_trng_en", 32'(trng_en), 32'd0);
        check("t4_valid", 32'(rnd_valid), 32'd0);
        alt(3);
        check("t4_fail_sticky", 32'(health_fail), 32'd1);
        enable = 1'b0; cyc();
        check("t4_fail_cleared", 32'(health_fail), 32'd0);
        check("t4_idle_trng_en", 32'(trng_en), 32'd0);

        // T5: abort after 3 accepted bits, re-enable, full warmup and a clean word
        cyc();
        enable = 1'b1; cyc();
        alt(7);
        enable = 1'b0; alt(1);
        check("t5_abort_trng_en", 32'(trng_en), 32'd0);
        check("t5_abort_valid", 32'(rnd_valid), 32'd0);
        cyc();
        enable = 1'b1; cyc();
        check("t5_rearm_trng_en", 32'(trng_en), 32'd1);
        alt(2);
        feed(32'hCA, 8);
        alt(2);
        check("t5_valid_early", 32'(rnd_valid), 32'd0);
        alt(1);
        check("t5_valid", 32'(rnd_valid), 32'd1);
        check("t5_data", 32'(rnd_data), 32'h0000_00CA);

        // T6: reset while FULL with enable still high
        reset = 1'b1; cyc();
        check("t6_trng_en", 32'(trng_en), 32'd0);
        check("t6_valid", 32'(rnd_valid), 32'd0);
        check("t6_data", 32'(rnd_data), 32'd0);
        check("t6_health_fail", 32'(health_fail), 32'd0);
        reset = 1'b0; cyc();
        check("t6_restart_trng_en", 32'(trng_en), 32'd1);
        enable = 1'b0; cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
